fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//  Instruction-fetch datapath driven by the CPU control state machine.
//  - Holds the 13-bit program counter (PC).
//  - Assembles the 16-bit instruction register (IR) from two 8-bit bus bytes, high byte first.
//  - Returns opcode to the controller and drives the memory address mux.
//  - Consumes controller strobes load_ir, inc_pc, load_pc, halt; produces opcode for it.
//
// PARAMETERS
//  ADDR_W  13  PC / operand address width (IR[12:0])
//  DATA_W  8   data bus width; IR width = 2*DATA_W
//  OPC_W   3   opcode width (IR[15:13])
//
// PORTS
//  clk       in   1       clock, all state updates on rising edge
//  rst       in   1       synchronous reset, active-high
//  ena       in   1       run enable; low = hold PC, force byte phase to HI
//  load_ir   in   1       capture data into IR at current byte phase
//  inc_pc    in   1       PC <= PC+1
//  load_pc   in   1       PC <= ir_addr
//  halt      in   1       freeze PC until rst
//  fetch     in   1       address mux select: 1 = PC, 0 = ir_addr
//  data      in   DATA_W  memory read bus
//  opcode    out  OPC_W   IR[15:13], to controller
//  ir_addr   out  ADDR_W  IR[12:0]
//  pc        out  ADDR_W  current PC
//  addr      out  ADDR_W  memory address = fetch ? pc : ir_addr (combinational)
//  ir_valid  out  1       both IR bytes captured since last HI-byte load
//  halted    out  1       sticky halt flag
//
// BEHAVIOUR
//  Reset (rst=1 at edge):
//  - pc=0, IR=0 (opcode=0, ir_addr=0), ir_valid=0, halted=0, phase=HI.
//  - rst overrides every other input.
//  Byte FSM (phase: HI, LO); acts only when ena=1 and load_ir=1:
//  - HI: IR[15:8]<=data; ir_valid<=0; ->LO.
//  - LO: IR[7:0]<=data; ir_valid<=1; ->HI.
//  - load_ir=0: phase, IR and ir_valid hold.
//  - ena=0: phase<=HI; IR and ir_valid hold. A pending LO is abandoned; the next load_ir is HI.
//  - IR fields update one edge after capture. opcode/ir_addr are registered, no extra latency.
//  PC (when ena=1 and halted=0):
//  - load_pc=1: pc<=ir_addr. Has priority over inc_pc when both are asserted.
//  - else inc_pc=1: pc<=pc+1 mod 2^ADDR_W (0x1FFF -> 0x0000).
//  - else hold.
//  - load_pc uses the IR value before any same-edge load_ir update.
//  - PC updates and IR capture on the same edge are independent.
//  Halt:
//  - halt=1 with ena=1 sets halted<=1 at that edge. Sticky until rst.
//  - Same-edge inc_pc/load_pc still apply; later PC strobes are ignored.
//  - While halted, IR capture continues.
//  addr: pure mux of registered values, no clock latency.
//
// STRUCTURE
//  - cpu_pkg (shared):
//    - localparams HLT=0, SKZ=1, ADD=2, ANDD=3, XORR=4, LDA=5, STO=6, JMP=7.
//    - ADDR_W, DATA_W, OPC_W defaults.
//    - Phase encodings PH_HI=1'b0, PH_LO=1'b1.
//  - Sub-module pc_counter: load/inc/hold/halt logic for PC.
//  - IR byte FSM and addr mux stay in fetch_unit.
//
// TESTING
//  1. rst=1 for 2 clks -> pc=0, opcode=0, ir_addr=0, ir_valid=0, halted=0.
//  2. load_ir pulses with data=0xB2 then 0x34:
//     - after the 2nd edge: opcode=5 (LDA), ir_addr=0x1234, ir_valid=1.
//     - next load_ir with 0xE0 clears ir_valid.
//  3. PC=0x1FFF, inc_pc one clk -> pc=0x0000 (wrap).
//  4. IR=0xE123 (JMP, 0x0123), load_pc=1 and inc_pc=1 on the same edge -> pc=0x0123, not 0x0124.
//  5. HI byte loaded, ena=0 one clk, then load_ir data=0x40 -> captured as HI byte: opcode=2, ir_valid=0.
//  6. halt=1 at pc=5 with inc_pc=1 -> pc=6, halted=1.
//     - further inc_pc/load_pc -> pc stays 6.
//     - rst -> pc=0, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and byte-phase encodings for the CPU datapath
package cpu_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3,
                         XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  localparam logic PH_HI = 1'b0;
  localparam logic PH_LO = 1'b1;
endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with load-over-increment priority and sticky halt
module pc_counter #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              halt,
  input  logic              load_pc,
  input  logic              inc_pc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (ena && !halted) begin
      pc <= load_pc ? load_val : inc_pc ? pc + 1'b1 : pc;
      if (halt) halted <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, two-byte IR assembly (high byte first) and memory address mux
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int OPC_W  = cpu_pkg::OPC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              halt,
  input  logic              fetch,
  input  logic [DATA_W-1:0] data,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] addr,
  output logic              ir_valid,
  output logic              halted
);
  logic                  phase;
  logic [2*DATA_W-1:0]   ir;
  assign opcode  = ir[2*DATA_W-1 -: OPC_W];
  assign ir_addr = ir[ADDR_W-1:0];
  assign addr    = fetch ? pc : ir_addr;
  // dropping ena abandons a half-assembled word so the next byte is always the high one
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_HI;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (!ena) begin
      phase <= PH_HI;
    end else if (load_ir) begin
      if (phase == PH_HI) begin
        ir[2*DATA_W-1:DATA_W] <= data;
        ir_valid              <= 1'b0;
        phase                 <= PH_LO;
      end else begin
        ir[DATA_W-1:0] <= data;
        ir_valid       <= 1'b1;
        phase          <= PH_HI;
      end
    end
  end
  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk(clk), .rst(rst), .ena(ena), .halt(halt), .load_pc(load_pc),
    .inc_pc(inc_pc), .load_val(ir_addr), .pc(pc), .halted(halted)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random stimulus against a word-level reference model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, ena, load_ir, inc_pc, load_pc, halt, fetch;
  logic [7:0]  data;
  logic [2:0]  opcode;
  logic [12:0] ir_addr, pc, addr;
  logic ir_valid, halted;
  int n_cmp = 0, n_bad = 0;
  int m_pc, m_ir;
  bit m_lo, m_valid, m_halted;

  fetch_unit dut (
    .clk(clk), .rst(rst), .ena(ena), .load_ir(load_ir), .inc_pc(inc_pc),
    .load_pc(load_pc), .halt(halt), .fetch(fetch), .data(data),
    .opcode(opcode), .ir_addr(ir_addr), .pc(pc), .addr(addr),
    .ir_valid(ir_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int old_target;
    old_target = m_ir % 8192;
    if (rst) begin
      m_pc = 0; m_ir = 0; m_lo = 0; m_valid = 0; m_halted = 0;
    end else begin
      if (ena && !m_halted) begin
        if (load_pc) m_pc = old_target;
        else if (inc_pc) m_pc = (m_pc + 1) % 8192;
        if (halt) m_halted = 1;
      end
      if (!ena) m_lo = 0;
      else if (load_ir) begin
        if (!m_lo) begin
          m_ir = int'(data) * 256 + m_ir % 256;
          m_valid = 0;
        end else begin
          m_ir = (m_ir / 256) * 256 + int'(data);
          m_valid = 1;
        end
        m_lo = !m_lo;
      end
    end
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("opcode", 32'(opcode), 32'(m_ir / 8192));
    chk("ir_addr", 32'(ir_addr), 32'(m_ir % 8192));
    chk("ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("addr", 32'(addr), fetch ? 32'(m_pc) : 32'(m_ir % 8192));
  endtask

  task automatic cyc(input logic r, e, li, ip, lp, h, f, input logic [7:0] d);
    rst = r; ena = e; load_ir = li; inc_pc = ip; load_pc = lp; halt = h; fetch = f; data = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load_word(input logic [7:0] hi, input logic [7:0] lo);
    cyc(0, 1, 1, 0, 0, 0, 1, hi);
    cyc(0, 1, 1, 0, 0, 0, 1, lo);
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_lo = 0; m_valid = 0; m_halted = 0;
    cyc(1, 0, 0, 0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 1, 8'h00);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_ir_addr", 32'(ir_addr), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_halted", 32'(halted), 0);

    load_word(8'hB2, 8'h34);
    chk("lda_opcode", 32'(opcode), 5);
    chk("lda_addr", 32'(ir_addr), 32'h1234);
    chk("lda_valid", 32'(ir_valid), 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 8'hE0);
    chk("hi_clears_valid", 32'(ir_valid), 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h00);

    load_word(8'h1F, 8'hFF);
    cyc(0, 1, 0, 0, 1, 0, 1, 8'h00);
    chk("pc_1fff", 32'(pc), 32'h1FFF);
    cyc(0, 1, 0, 1, 0, 0, 1, 8'h00);
    chk("pc_wrap", 32'(pc), 0);

    load_word(8'hE1, 8'h23);
    cyc(0, 1, 0, 1, 1, 0, 1, 8'h00);
    chk("load_over_inc", 32'(pc), 32'h0123);
    cyc(0, 1, 1, 0, 1, 0, 1, 8'h77);
    chk("load_pc_old_ir", 32'(pc), 32'h0123);
    cyc(0, 1, 1, 0, 0, 0, 1, 8'h88);

    cyc(0, 1, 1, 0, 0, 0, 1, 8'hB2);
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h00);
    cyc(0, 1, 1, 0, 0, 0, 1, 8'h40);
    chk("abandon_opcode", 32'(opcode), 2);
    chk("abandon_valid", 32'(ir_valid), 0);
    cyc(0, 1, 1, 0, 0, 0, 1, 8'h05);
    chk("abandon_lo", 32'(ir_addr), 32'h0005);

    cyc(0, 1, 0, 0, 1, 0, 1, 8'h00);
    cyc(0, 1, 0, 1, 0, 1, 1, 8'h00);
    chk("halt_pc", 32'(pc), 6);
    chk("halt_flag", 32'(halted), 1);
    cyc(0, 1, 0, 1, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 1, 0, 1, 8'h00);
    chk("halt_frozen", 32'(pc), 6);
    load_word(8'h6A, 8'hBC);
    chk("halt_ir_capture", 32'(ir_addr), 32'h0ABC);
    cyc(1, 1, 0, 0, 0, 0, 1, 8'h00);
    chk("unhalt_pc", 32'(pc), 0);
    chk("unhalt_flag", 32'(halted), 0);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 64) == 0, ($urandom % 8) != 0, $urandom % 2, $urandom % 2,
          ($urandom % 4) == 0, ($urandom % 40) == 0, $urandom % 2, 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
